// File: rtl/conv_window9_pkg.sv
// Shared types and sizes for the conv_window9 raster-to-window front end.
package conv_window9_pkg;

    localparam int unsigned DWIDTH = 16;
    localparam int unsigned MAXW   = 256;
    localparam int unsigned LWIDTH = 9;
    localparam int unsigned NTAPS  = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Nine window pixels, row-major; element 0 is top-left, 4 centre, 8 bottom-right.
    typedef logic signed [NTAPS-1:0][DWIDTH-1:0] window_t;

endpackage

// File: rtl/conv_window9_line_buf.sv
// One image-row line buffer: combinational read, synchronous write (read-before-write).
module window_line_buf
    import conv_window9_pkg::*;
#(
    parameter int unsigned DEPTH = MAXW,
    parameter int unsigned DW    = DWIDTH,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    // Old contents are visible to the reader in the same cycle as the write.
    assign o_rdata = r_mem[i_addr];

    // Store the new pixel for this column.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/conv_window9.sv
// Raster-to-3x3-window front end for the convolution tree.
// Optional feature: define CONV_WINDOW_STRIDE2_EN to add the stride2 input,
// which, when latched high, emits only windows at even row/column offsets.
module conv_window9
    import conv_window9_pkg::*;
(
    input  logic                      clk,
    input  logic                      xrst,
    input  logic                      start,
    input  logic [LWIDTH-1:0]         img_w,
    input  logic [LWIDTH-1:0]         img_h,
    input  logic                      in_valid,
    input  logic signed [DWIDTH-1:0]  in_pixel,
`ifdef CONV_WINDOW_STRIDE2_EN
    input  logic                      stride2,
`endif
    output logic                      out_valid,
    output logic [NTAPS*DWIDTH-1:0]   out_pixel,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned AW = $clog2(MAXW);

    state_t              r_state;
    logic [LWIDTH-1:0]   r_row;
    logic [LWIDTH-1:0]   r_col;
    logic [LWIDTH-1:0]   r_w;
    logic [LWIDTH-1:0]   r_h;
    logic                r_busy;
    logic                r_done;
    logic                r_out_valid;
    window_t             r_win;
    window_t             r_out;
`ifdef CONV_WINDOW_STRIDE2_EN
    logic                r_stride2;
`endif

    logic                w_beat;
    logic                w_legal;
    logic                w_last_col;
    logic                w_last_row;
    logic                w_emit;
    logic [AW-1:0]       w_addr;
    logic [DWIDTH-1:0]   w_mid;
    logic [DWIDTH-1:0]   w_top;
    window_t             w_win_nxt;

    assign w_beat     = (r_state == ST_RUN) && in_valid;
    assign w_legal    = (img_w >= LWIDTH'(3)) && (img_w <= LWIDTH'(MAXW)) && (img_h >= LWIDTH'(3));
    assign w_last_col = (r_col == r_w - LWIDTH'(1));
    assign w_last_row = (r_row == r_h - LWIDTH'(1));
    assign w_addr     = r_col[AW-1:0];

    // lb0 holds row-1, lb1 holds row-2; lb1 is refilled from lb0's old value.
    window_line_buf #(.DEPTH(MAXW), .DW(DWIDTH)) lb0 (
        .clk     (clk),
        .i_we    (w_beat),
        .i_addr  (w_addr),
        .i_wdata (in_pixel),
        .o_rdata (w_mid)
    );

    window_line_buf #(.DEPTH(MAXW), .DW(DWIDTH)) lb1 (
        .clk     (clk),
        .i_we    (w_beat),
        .i_addr  (w_addr),
        .i_wdata (w_mid),
        .o_rdata (w_top)
    );

    // Window emission: interior positions only; stale columns masked by col >= 2.
    always_comb begin
        w_emit = (r_row >= LWIDTH'(2)) && (r_col >= LWIDTH'(2));
`ifdef CONV_WINDOW_STRIDE2_EN
        if (r_stride2) begin
            w_emit = w_emit && !r_row[0] && !r_col[0];
        end
`endif
    end

    // Next 3x3 contents: shift left one column and load the new column taps on the right.
    always_comb begin
        w_win_nxt = r_win;
        for (int r = 0; r < 3; r++) begin
            w_win_nxt[r*3]     = r_win[r*3+1];
            w_win_nxt[r*3 + 1] = r_win[r*3+2];
        end
        w_win_nxt[2] = w_top;
        w_win_nxt[5] = w_mid;
        w_win_nxt[8] = in_pixel;
    end

    // Frame FSM, raster counters, window register and registered outputs.
    always_ff @(posedge clk) begin
        if (xrst) begin
            r_state     <= ST_IDLE;
            r_row       <= '0;
            r_col       <= '0;
            r_w         <= '0;
            r_h         <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_win       <= '0;
            r_out       <= '0;
`ifdef CONV_WINDOW_STRIDE2_EN
            r_stride2   <= 1'b0;
`endif
        end else begin
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && w_legal) begin
                        r_w     <= img_w;
                        r_h     <= img_h;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
`ifdef CONV_WINDOW_STRIDE2_EN
                        r_stride2 <= stride2;
`endif
                    end
                end
                ST_RUN: begin
                    if (in_valid) begin
                        r_win <= w_win_nxt;
                        if (w_emit) begin
                            r_out       <= w_win_nxt;
                            r_out_valid <= 1'b1;
                        end
                        if (w_last_col) begin
                            r_col <= '0;
                            r_row <= r_row + LWIDTH'(1);
                            if (w_last_row) begin
                                r_done  <= 1'b1;
                                r_state <= ST_DONE;
                            end
                        end else begin
                            r_col <= r_col + LWIDTH'(1);
                        end
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_pixel = r_out;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_conv_window9.sv
// Scoreboard bench for conv_window9: a frame model pushes expected windows, a monitor pops them.
module tb_conv_window9;
    import conv_window9_pkg::*;

    localparam int unsigned WB = NTAPS*DWIDTH;

    logic                     clk = 1'b0;
    logic                     xrst;
    logic                     start;
    logic [LWIDTH-1:0]        img_w;
    logic [LWIDTH-1:0]        img_h;
    logic                     in_valid;
    logic signed [DWIDTH-1:0] in_pixel;
`ifdef CONV_WINDOW_STRIDE2_EN
    logic                     stride2;
`endif
    logic                     out_valid;
    logic [WB-1:0]            out_pixel;
    logic                     busy;
    logic                     done;

    conv_window9 dut (
        .clk       (clk),
        .xrst      (xrst),
        .start     (start),
        .img_w     (img_w),
        .img_h     (img_h),
        .in_valid  (in_valid),
        .in_pixel  (in_pixel),
`ifdef CONV_WINDOW_STRIDE2_EN
        .stride2   (stride2),
`endif
        .out_valid (out_valid),
        .out_pixel (out_pixel),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int            errors = 0;
    int            checks = 0;
    int            win_cnt = 0;
    int            done_cnt = 0;
    logic [WB-1:0] exp_q [$];
    logic [DWIDTH-1:0] frame_q [$];
    logic          prev_iv = 1'b0;
    logic          prev_rst = 1'b0;
    logic          prev_done = 1'b0;
    logic          last_emits = 1'b0;
    logic [WB-1:0] last_out = '0;

    task automatic chkw(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Previous-edge view of the inputs the DUT just sampled.
    always @(posedge clk) begin
        prev_iv  <= in_valid;
        prev_rst <= xrst;
    end

    // Monitor: pop and compare on every presented window, and check done/busy/hold behaviour.
    always @(negedge clk) begin
        if (prev_rst) begin
            chki("reset_out_valid", int'(out_valid), 0);
            chkw("reset_out_pixel", out_pixel, '0);
            chki("reset_busy", int'(busy), 0);
            chki("reset_done", int'(done), 0);
            last_out  = '0;
            prev_done = 1'b0;
        end else begin
            if (out_valid) begin
                chki("valid_after_beat", int'(prev_iv), 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_window: got %h expected none", out_pixel);
                end else begin
                    last_out = exp_q.pop_front();
                    chkw("window", out_pixel, last_out);
                end
                win_cnt++;
            end else begin
                chkw("hold_pixel", out_pixel, last_out);
            end
            if (done) begin
                if (last_emits) chki("done_with_last_window", int'(out_valid), 1);
                chki("done_busy", int'(busy), 1);
                chki("done_queue_empty", exp_q.size(), 0);
                done_cnt++;
            end
            if (prev_done) chki("busy_after_done", int'(busy), 0);
            prev_done = done;
        end
    end

    task automatic build_seq(input int n, input int base);
        frame_q.delete();
        for (int i = 0; i < n; i++) frame_q.push_back(DWIDTH'(base + i));
    endtask

    task automatic build_rand(input int n);
        frame_q.delete();
        for (int i = 0; i < n; i++) frame_q.push_back(DWIDTH'($urandom));
    endtask

    // Reference: window at bottom-right (r,c) is the 3x3 block of the stored frame.
    function automatic logic [WB-1:0] model_window(input int w, input int r, input int c);
        logic [WB-1:0] e;
        e = '0;
        for (int k = 0; k < 9; k++)
            e[k*DWIDTH +: DWIDTH] = frame_q[(r - 2 + k/3)*w + (c - 2 + k%3)];
        return e;
    endfunction

    function automatic bit model_emits(input int r, input int c, input bit s2);
        return (r >= 2) && (c >= 2) && (!s2 || (((r - 2) % 2 == 0) && ((c - 2) % 2 == 0)));
    endfunction

    // gap: 0 continuous, 1 toggle 1/0, 2 random gaps.
    task automatic send_frame(input int w, input int h, input bit s2, input int gap);
        int d0;
        int exp_n;
        d0      = done_cnt;
        win_cnt = 0;
        exp_n   = s2 ? ((w - 1)/2)*((h - 1)/2) : (w - 2)*(h - 2);
        last_emits = model_emits(h - 1, w - 1, s2);
        @(negedge clk);
        start = 1'b1;
        img_w = LWIDTH'(w);
        img_h = LWIDTH'(h);
`ifdef CONV_WINDOW_STRIDE2_EN
        stride2 = s2;
`endif
        @(negedge clk);
        start = 1'b0;
        chki("busy_after_start", int'(busy), 1);
        for (int i = 0; i < w*h; i++) begin
            int r;
            int c;
            int ng;
            r  = i / w;
            c  = i % w;
            ng = (gap == 1) ? ((i == 0) ? 0 : 1) : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
            if (ng > 0) begin
                in_valid = 1'b0;
                in_pixel = DWIDTH'($urandom);
                repeat (ng) @(negedge clk);
            end
            in_valid = 1'b1;
            in_pixel = frame_q[i];
            if (model_emits(r, c, s2)) exp_q.push_back(model_window(w, r, c));
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chki("done_pulse_count", done_cnt - d0, 1);
        chki("window_count", win_cnt, exp_n);
    endtask

    task automatic try_illegal(input int w, input int h);
        @(negedge clk);
        start = 1'b1;
        img_w = LWIDTH'(w);
        img_h = LWIDTH'(h);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_pixel = DWIDTH'($urandom);
        for (int i = 0; i < 3; i++) begin
            chki("illegal_busy", int'(busy), 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        xrst     = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_pixel = '0;
        img_w    = '0;
        img_h    = '0;
`ifdef CONV_WINDOW_STRIDE2_EN
        stride2  = 1'b0;
`endif
        repeat (3) @(negedge clk);
        xrst = 1'b0;

        // 4x4 ramp, continuous then toggling valid.
        build_seq(16, 0);
        send_frame(4, 4, 1'b0, 0);
        send_frame(4, 4, 1'b0, 1);

        // Narrowest width with signed extremes, then illegal sizes.
        build_rand(15);
        frame_q[0]  = 16'h8000;
        frame_q[4]  = 16'h7fff;
        frame_q[8]  = 16'h8000;
        frame_q[14] = 16'h7fff;
        send_frame(3, 5, 1'b0, 0);
        try_illegal(2, 5);
        try_illegal(257, 4);
        try_illegal(5, 2);

        // Reset in row 2 of a 4x4 frame, then a fresh frame.
        build_seq(16, 0);
        @(negedge clk);
        start = 1'b1;
        img_w = LWIDTH'(4);
        img_h = LWIDTH'(4);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_pixel = frame_q[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        xrst     = 1'b1;
        exp_q.delete();
        @(negedge clk);
        xrst = 1'b0;
        build_seq(16, 100);
        send_frame(4, 4, 1'b0, 0);

        // Random frames with random gaps, plus the maximum width.
        for (int f = 0; f < 6; f++) begin
            int w;
            int h;
            w = int'($urandom_range(3, 12));
            h = int'($urandom_range(3, 6));
            build_rand(w*h);
            send_frame(w, h, 1'b0, 2);
        end
        build_rand(MAXW*3);
        send_frame(MAXW, 3, 1'b0, 0);

        // 5x5 ramp at stride 1 and, when built in, stride 2.
        build_seq(25, 0);
        send_frame(5, 5, 1'b0, 0);
`ifdef CONV_WINDOW_STRIDE2_EN
        send_frame(5, 5, 1'b1, 1);
        send_frame(5, 5, 1'b0, 0);
`endif

        repeat (3) @(negedge clk);
        chki("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
